// File: rtl/vram_arb_pkg.sv
// Constants and the grant encoding shared by the VRAM arbiter, the display
// controller and the drawing engine.
package vram_arb_pkg;

  localparam int VRAM_ADDRW = 14;
  localparam int VRAM_WORD  = 32;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_sel_e;

  // Returns {grant_valid, grant_sel}. A wins ties unless force_b is set.
  function automatic logic [1:0] arb_prio2(input logic req_a,
                                           input logic req_b,
                                           input logic force_b);
    logic [1:0] g;
    g = 2'b00;
    if (req_a && req_b) g = {1'b1, force_b};
    else if (req_a)     g = {1'b1, 1'b0};
    else if (req_b)     g = {1'b1, 1'b1};
    return g;
  endfunction

endpackage

// File: rtl/vram_arb_if.sv
// Bundle of both requester ports plus the VRAM system-port signals.
// Handshake: a requester holds req (with addr/wmask/din stable) until it sees
// ack high in the same cycle; that cycle issues the access, and a read
// (wmask == 0) returns dout with rvalid exactly one cycle later.
interface vram_arb_if #(
  parameter int WORD  = 32,
  parameter int ADDRW = 14
);
  logic             a_req;
  logic             a_ack;
  logic [ADDRW-1:0] a_addr;
  logic [WORD-1:0]  a_wmask;
  logic [WORD-1:0]  a_din;
  logic [WORD-1:0]  a_dout;
  logic             a_rvalid;

  logic             b_req;
  logic             b_ack;
  logic [ADDRW-1:0] b_addr;
  logic [WORD-1:0]  b_wmask;
  logic [WORD-1:0]  b_din;
  logic [WORD-1:0]  b_dout;
  logic             b_rvalid;

  logic [ADDRW-1:0] vram_addr;
  logic [WORD-1:0]  vram_wmask;
  logic [WORD-1:0]  vram_din;
  logic [WORD-1:0]  vram_dout;

  // Arbiter side.
  modport slave (
    input  a_req, a_addr, a_wmask, a_din,
    output a_ack, a_dout, a_rvalid,
    input  b_req, b_addr, b_wmask, b_din,
    output b_ack, b_dout, b_rvalid,
    output vram_addr, vram_wmask, vram_din,
    input  vram_dout
  );

  // Client and VRAM side.
  modport master (
    output a_req, a_addr, a_wmask, a_din,
    input  a_ack, a_dout, a_rvalid,
    output b_req, b_addr, b_wmask, b_din,
    input  b_ack, b_dout, b_rvalid,
    input  vram_addr, vram_wmask, vram_din,
    output vram_dout
  );

endinterface

// File: rtl/vram_arb.sv
// Two-port VRAM system-port arbiter: A (CPU) has fixed priority, B (2D/DMA)
// is forced through after B_MAX consecutive contested A grants.
module vram_arb
  import vram_arb_pkg::*;
#(
  parameter int WORD  = VRAM_WORD,
  parameter int ADDRW = VRAM_ADDRW,
  parameter int B_MAX = 4
) (
  input  logic       clk_sys,
  input  logic       rst_sys,
  vram_arb_if.slave  bus,
  output logic [3:0] starve_cnt,
  output logic       grant_valid,
  output req_sel_e   grant_sel
);

  localparam logic [3:0] B_LIM = 4'(B_MAX);

  logic [ADDRW-1:0] last_addr;
  logic             rd_a;
  logic             rd_b;
  logic [1:0]       grant;

  // No grants while reset is held; pending requests are simply not acked.
  always_comb begin
    grant = 2'b00;
    if (!rst_sys) grant = arb_prio2(bus.a_req, bus.b_req, starve_cnt == B_LIM);
  end

  assign grant_valid = grant[1];
  assign grant_sel   = req_sel_e'(grant[0]);
  assign bus.a_ack   = grant_valid && (grant_sel == REQ_A);
  assign bus.b_ack   = grant_valid && (grant_sel == REQ_B);

  // Idle cycles re-read the last granted address so vram_dout stays put.
  always_comb begin
    bus.vram_addr  = last_addr;
    bus.vram_wmask = '0;
    bus.vram_din   = '0;
    if (bus.a_ack) begin
      bus.vram_addr  = bus.a_addr;
      bus.vram_wmask = bus.a_wmask;
      bus.vram_din   = bus.a_din;
    end else if (bus.b_ack) begin
      bus.vram_addr  = bus.b_addr;
      bus.vram_wmask = bus.b_wmask;
      bus.vram_din   = bus.b_din;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      starve_cnt <= 4'd0;
      rd_a       <= 1'b0;
      rd_b       <= 1'b0;
      last_addr  <= '0;
    end else begin
      rd_a <= bus.a_ack && (bus.a_wmask == '0);
      rd_b <= bus.b_ack && (bus.b_wmask == '0);
      if (grant_valid) last_addr <= bus.vram_addr;
      if (bus.b_req && bus.a_ack)
        starve_cnt <= (starve_cnt == B_LIM) ? starve_cnt : starve_cnt + 4'd1;
      else
        starve_cnt <= 4'd0;
    end
  end

  // A read granted just before reset must not report data during reset.
  assign bus.a_rvalid = rd_a && !rst_sys;
  assign bus.b_rvalid = rd_b && !rst_sys;
  assign bus.a_dout   = bus.vram_dout;
  assign bus.b_dout   = bus.vram_dout;

endmodule

// File: tb/tb_vram_arb.sv
// Directed bench for vram_arb with a behavioural no-change-mode VRAM model.
module tb_vram_arb;
  import vram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  starve_cnt;
  logic        grant_valid;
  req_sel_e    grant_sel;
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];

  vram_arb_if #(.WORD(32), .ADDRW(14)) bus ();

  vram_arb #(.WORD(32), .ADDRW(14), .B_MAX(4)) dut (
    .clk_sys    (clk),
    .rst_sys    (rst),
    .bus        (bus),
    .starve_cnt (starve_cnt),
    .grant_valid(grant_valid),
    .grant_sel  (grant_sel)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // VRAM model: synchronous read; writes leave dout unchanged.
  logic [31:0] mem [0:16383];
  logic [31:0] vram_q = 32'h0;
  initial for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
  always @(posedge clk) begin
    if (bus.vram_wmask == 32'h0) vram_q <= mem[bus.vram_addr];
    else mem[bus.vram_addr] <= (mem[bus.vram_addr] & ~bus.vram_wmask) |
                               (bus.vram_din & bus.vram_wmask);
  end
  assign bus.vram_dout = vram_q;

  // driver tasks
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic set_a(input logic req, input logic [13:0] addr,
                       input logic [31:0] wmask, input logic [31:0] din);
    bus.a_req = req; bus.a_addr = addr; bus.a_wmask = wmask; bus.a_din = din;
  endtask

  task automatic set_b(input logic req, input logic [13:0] addr,
                       input logic [31:0] wmask, input logic [31:0] din);
    bus.b_req = req; bus.b_addr = addr; bus.b_wmask = wmask; bus.b_din = din;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input logic is_b, input string tag);
    logic        rv;
    logic [31:0] d;
    rv = is_b ? bus.b_rvalid : bus.a_rvalid;
    d  = is_b ? bus.b_dout : bus.a_dout;
    chk({tag, "_rvalid"}, 32'(rv), 32'd1);
    if (exp_q.size() == 0) chk({tag, "_q"}, 32'd0, 32'd1);
    else chk({tag, "_dout"}, d, exp_q.pop_front());
  endtask

  initial begin
    set_a(1'b1, 14'h3ff, 32'h0, 32'h0);
    set_b(1'b1, 14'h000, 32'h0, 32'h0);
    rst = 1'b1;

    // reset with both requests pending
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("rst_a_ack", 32'(bus.a_ack), 32'd0);
      chk("rst_b_ack", 32'(bus.b_ack), 32'd0);
      chk("rst_a_rv", 32'(bus.a_rvalid), 32'd0);
      chk("rst_b_rv", 32'(bus.b_rvalid), 32'd0);
      chk("rst_vaddr", 32'(bus.vram_addr), 32'd0);
      nxt();
    end
    rst = 1'b0;
    smp();
    chk("rel_a_ack", 32'(bus.a_ack), 32'd1);
    chk("rel_b_ack", 32'(bus.b_ack), 32'd0);
    chk("rel_cnt", 32'(starve_cnt), 32'd0);
    chk("rel_vaddr", 32'(bus.vram_addr), 32'h3ff);
    exp_q.push_back(32'h0);
    nxt();
    bus.a_req = 1'b0;
    smp();
    check_rd(1'b0, "rel_a");
    chk("rel_b_kept", 32'(bus.b_ack), 32'd1);
    exp_q.push_back(32'h0);
    nxt();
    bus.b_req = 1'b0;
    smp();
    check_rd(1'b1, "rel_b");
    chk("rel_a_rv0", 32'(bus.a_rvalid), 32'd0);
    nxt();

    // single B write then B read
    set_b(1'b1, 14'h0123, 32'hffffffff, 32'hdeadbeef);
    smp();
    chk("bw_ack", 32'(bus.b_ack), 32'd1);
    chk("bw_a_ack", 32'(bus.a_ack), 32'd0);
    chk("bw_vaddr", 32'(bus.vram_addr), 32'h0123);
    chk("bw_wmask", bus.vram_wmask, 32'hffffffff);
    chk("bw_din", bus.vram_din, 32'hdeadbeef);
    nxt();
    set_b(1'b1, 14'h0123, 32'h0, 32'h0);
    exp_q.push_back(32'hdeadbeef);
    smp();
    chk("br_ack", 32'(bus.b_ack), 32'd1);
    chk("bw_no_rv", 32'(bus.b_rvalid), 32'd0);
    nxt();
    set_b(1'b0, 14'h0, 32'h0, 32'h0);
    smp();
    check_rd(1'b1, "br");
    chk("br_a_rv0", 32'(bus.a_rvalid), 32'd0);
    chk("idle_wmask", bus.vram_wmask, 32'h0);
    chk("idle_din", bus.vram_din, 32'h0);
    chk("idle_vaddr", 32'(bus.vram_addr), 32'h0123);
    nxt();
    smp();
    chk("br_rv_once", 32'(bus.b_rvalid), 32'd0);
    nxt();

    // starvation bound: A,A,A,A,B repeating
    set_a(1'b1, 14'h10, 32'h0, 32'h0);
    set_b(1'b1, 14'h20, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      int ec;
      ec = i % 5;
      smp();
      chk("stv_cnt", 32'(starve_cnt), 32'(ec));
      chk("stv_a_ack", 32'(bus.a_ack), (ec == 4) ? 32'd0 : 32'd1);
      chk("stv_b_ack", 32'(bus.b_ack), (ec == 4) ? 32'd1 : 32'd0);
      nxt();
    end
    set_a(1'b0, 14'h0, 32'h0, 32'h0);
    set_b(1'b0, 14'h0, 32'h0, 32'h0);
    nxt();
    smp();
    chk("stv_clear", 32'(starve_cnt), 32'd0);
    nxt();

    // partial write
    set_a(1'b1, 14'd5, 32'hffffffff, 32'hffffffff);
    smp();
    chk("pw_full_ack", 32'(bus.a_ack), 32'd1);
    nxt();
    set_a(1'b1, 14'd5, 32'h0000ff00, 32'h0);
    smp();
    chk("pw_wmask", bus.vram_wmask, 32'h0000ff00);
    chk("pw_din", bus.vram_din, 32'h0);
    nxt();
    set_a(1'b1, 14'd5, 32'h0, 32'h0);
    exp_q.push_back(32'hffff00ff);
    smp();
    chk("pr_ack", 32'(bus.a_ack), 32'd1);
    nxt();
    set_a(1'b0, 14'd0, 32'h0, 32'h0);
    smp();
    check_rd(1'b0, "pr");
    nxt();

    // back-to-back read / write / read on addr 7
    set_a(1'b1, 14'd7, 32'hffffffff, 32'h11);
    smp();
    nxt();
    set_a(1'b1, 14'd7, 32'h0, 32'h0);
    exp_q.push_back(32'h11);
    smp();
    chk("bb_r1_ack", 32'(bus.a_ack), 32'd1);
    nxt();
    set_a(1'b0, 14'd0, 32'h0, 32'h0);
    set_b(1'b1, 14'd7, 32'hffffffff, 32'h22);
    smp();
    check_rd(1'b0, "bb_r1");
    chk("bb_w_ack", 32'(bus.b_ack), 32'd1);
    chk("bb_w_brv", 32'(bus.b_rvalid), 32'd0);
    nxt();
    set_b(1'b0, 14'd0, 32'h0, 32'h0);
    set_a(1'b1, 14'd7, 32'h0, 32'h0);
    exp_q.push_back(32'h22);
    smp();
    chk("bb_w_no_arv", 32'(bus.a_rvalid), 32'd0);
    chk("bb_w_no_brv", 32'(bus.b_rvalid), 32'd0);
    nxt();
    set_a(1'b0, 14'd0, 32'h0, 32'h0);
    smp();
    check_rd(1'b0, "bb_r2");
    nxt();

    // reset right after a read grant
    set_a(1'b1, 14'd5, 32'h0, 32'h0);
    smp();
    chk("mr_ack", 32'(bus.a_ack), 32'd1);
    nxt();
    rst = 1'b1;
    set_a(1'b1, 14'h30, 32'h0, 32'h0);
    set_b(1'b1, 14'h40, 32'h0, 32'h0);
    smp();
    chk("mr_rst_arv", 32'(bus.a_rvalid), 32'd0);
    chk("mr_rst_aack", 32'(bus.a_ack), 32'd0);
    chk("mr_rst_back", 32'(bus.b_ack), 32'd0);
    nxt();
    rst = 1'b0;
    smp();
    chk("mr_cnt", 32'(starve_cnt), 32'd0);
    chk("mr_a_first", 32'(bus.a_ack), 32'd1);
    chk("mr_b_wait", 32'(bus.b_ack), 32'd0);
    chk("mr_arv0", 32'(bus.a_rvalid), 32'd0);
    exp_q.push_back(32'h0);
    nxt();
    bus.a_req = 1'b0;
    smp();
    check_rd(1'b0, "mr_a");
    chk("mr_b_ack", 32'(bus.b_ack), 32'd1);
    exp_q.push_back(32'h0);
    nxt();
    bus.b_req = 1'b0;
    smp();
    check_rd(1'b1, "mr_b");
    chk("mr_hold_addr", 32'(bus.vram_addr), 32'h40);
    nxt();

    // final report
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_arb.md
Name: vram_arb

Overview:
- Two-requester arbiter for the VRAM system port; sits between its clients and VRAM in the clk_sys domain.
- Port A is the CPU bus and has fixed priority. Port B is the 2D drawing/DMA engine, protected from starvation by a bounded-wait counter.
- Drives the VRAM system-port address, bit write mask and data. Returns read data with a per-requester valid strobe, one cycle after grant.

Parameters:
- WORD, 32, machine word size (bits); must match VRAM.
- ADDRW, 14, VRAM word address width (bits); ≥14.
- B_MAX, 4, maximum consecutive contested A grants before B is forced through; 1..15.

Ports:
- clk_sys  in  1  system clock
- rst_sys  in  1  reset, synchronous, active-high
- a_req  in  1  port A request; held until a_ack
- a_ack  out  1  port A grant; access issued to VRAM this cycle
- a_addr  in  ADDRW  port A word address
- a_wmask  in  WORD  port A bit write mask; all-zero means read
- a_din  in  WORD  port A write data
- a_dout  out  WORD  port A read data
- a_rvalid  out  1  port A read data valid
- b_req, b_ack, b_addr, b_wmask, b_din, b_dout, b_rvalid: same as port A, for port B
- vram_addr  out  ADDRW  to VRAM addr_sys
- vram_wmask  out  WORD  to VRAM wmask_sys
- vram_din  out  WORD  to VRAM din_sys
- vram_dout  in  WORD  from VRAM dout_sys

Behaviour:
- Grant is combinational each cycle. A request is consumed on the cycle its ack is high; the requester may present a new request the following cycle.
- Arbitration:
  - Only A requests: grant A.
  - Only B requests: grant B.
  - Both request: grant B if starve_cnt == B_MAX, otherwise grant A.
  - Neither requests: no grant.
- Grant is never given to a requester whose req is low.
- At most one of a_ack/b_ack is high in any cycle.
- starve_cnt (4-bit register):
  - Increments when b_req is high and A is granted.
  - Clears on a B grant, or on any cycle b_req is low.
  - Saturates at B_MAX.
- VRAM mux:
  - vram_addr/vram_wmask/vram_din come from the granted port.
  - With no grant: vram_wmask = 0 (idle read, no write) and vram_addr holds the last granted address, so VRAM read data stays stable. vram_din is 0.
- Read return:
  - A read is a grant with wmask == 0.
  - Registered flags rd_a/rd_b set on the cycle after a read grant, for one cycle.
  - a_rvalid = rd_a and b_rvalid = rd_b; each is high for exactly one cycle, one cycle after ack.
- Read data:
  - a_dout = b_dout = vram_dout (pass-through). Data is meaningful only while the matching rvalid is high.
  - Writes produce no rvalid. VRAM no-change mode keeps vram_dout unchanged across writes.
- Back-to-back accesses:
  - A read on cycle N and a write on cycle N+1 is legal; rvalid for the read asserts on N+1 with the correct data.
  - Full throughput: one access per cycle.
- Reset:
  - starve_cnt = 0, rd_a = rd_b = 0, last address = 0. All outputs deassert: a_ack = b_ack = 0 and rvalid = 0 while rst_sys is high.
  - A read granted in the cycle before reset asserts produces no rvalid.
  - Requests present during reset are not acknowledged and are not lost; they are arbitrated from the first cycle after reset.
- Partial writes: the mask passes through unchanged; bit-level masking is performed by VRAM.

Decomposition:
- Shared package/header: a VRAM_ADDRW constant and a REQ_A/REQ_B grant encoding (1-bit select) shared with the display controller and the drawing engine.
- No sub-module needed. One always block holds the registered state (starve_cnt, rd_a, rd_b, last address); combinational logic handles grant and the mux.
- An optional tiny arb_prio2 function or module holds the grant logic only if later reused.

Test Plan:
- Reset then idle:
  - Hold rst_sys 3 cycles with a_req = b_req = 1 -> a_ack, b_ack, a_rvalid and b_rvalid are all 0 during reset.
  - On release, a_ack = 1 on the first cycle.
- Single read/write:
  - B writes 0xDEADBEEF with wmask 0xFFFFFFFF at addr 0x0123, then B reads 0x0123 -> b_ack on each.
  - b_rvalid is high the cycle after the read ack with b_dout = 0xDEADBEEF; a_rvalid stays 0.
- Starvation bound:
  - a_req and b_req held high continuously with B_MAX = 4 -> grant pattern A,A,A,A,B repeats.
  - starve_cnt reads 0,1,2,3,4,0.
- Partial write:
  - Write 0xFFFFFFFF to addr 5, then A writes 0x00000000 with wmask 0x0000FF00, then A reads addr 5 -> a_dout = 0xFFFF00FF with a_rvalid.
- Back-to-back mixed:
  - A read addr 7 (contains 0x11), B write addr 7 (0x22), A read addr 7 on consecutive cycles -> first a_rvalid carries 0x11, second carries 0x22; no rvalid for the write.
- Reset mid-operation:
  - A read ack on cycle N, rst_sys high on N+1 -> a_rvalid = 0 on N+1.
  - After release, starve_cnt = 0 and arbitration restarts with A first.
